// File: rtl/matrix_readout_pkg.sv
// Shared types and defaults for the pixel-matrix readout controller.
package matrix_readout_pkg;

  localparam int NCOL_DEF     = 56;
  localparam int DW_DEF       = 21;
  localparam int FRZ_WAIT_DEF = 4;
  localparam int RD_LEN_DEF   = 2;
  localparam int TOK_WAIT_DEF = 3;

  // Column data word layout: {LE[5:0], TE[5:0], row[8:0]}
  localparam int ROW_LSB = 0;
  localparam int ROW_W   = 9;
  localparam int TE_LSB  = 9;
  localparam int TE_W    = 6;
  localparam int LE_LSB  = 15;
  localparam int LE_W    = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FRZ,
    ST_SCAN,
    ST_RD,
    ST_OUT,
    ST_TOKW
  } state_t;

  // Width of the shared wait counter; it only ever holds (wait - 1).
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/matrix_readout_ctrl_if.sv
// Column-side (token/data/freeze/read) and stream-side (valid/ready) bundle.
interface matrix_readout_ctrl_if
  import matrix_readout_pkg::*;
#(
  parameter int NCOL = NCOL_DEF,
  parameter int DW   = DW_DEF,
  parameter int CW   = (NCOL > 1) ? $clog2(NCOL) : 1
);

  logic [NCOL-1:0]    nTOK;
  logic [NCOL*DW-1:0] Data;
  logic [NCOL-1:0]    FREEZE;
  logic [NCOL-1:0]    Read;
  logic [CW+DW-1:0]   out_data;
  logic               out_valid;
  logic               out_ready;

  modport master (
    input  nTOK, Data, out_ready,
    output FREEZE, Read, out_data, out_valid
  );

  modport slave (
    output nTOK, Data, out_ready,
    input  FREEZE, Read, out_data, out_valid
  );

endinterface

// File: rtl/matrix_readout_ctrl_col_prio_enc.sv
// Lowest-index-wins priority encoder over the column token requests.
module col_prio_enc #(
  parameter int NCOL = 56,
  parameter int CW   = (NCOL > 1) ? $clog2(NCOL) : 1
) (
  input  logic [NCOL-1:0] req,
  output logic            any,
  output logic [CW-1:0]   idx
);

  // Walk from the top down so the lowest requesting column is written last and wins.
  always_comb begin
    any = |req;
    idx = '0;
    for (int i = NCOL - 1; i >= 0; i--) begin
      if (req[i]) idx = CW'(i);
    end
  end

endmodule

// File: rtl/matrix_readout_ctrl.sv
// Readout sequencer for one front-end flavour: freezes the matrix, drains
// token-holding columns lowest index first and streams {col, data} words.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | matrix live, waiting for EN and any token
// FRZ     | FREEZE asserted, letting token chains settle
// SCAN    | pick lowest token column, or end the frame
// RD      | Read strobe on the picked column, data captured at the end
// OUT     | word presented downstream until accepted
// TOKW    | let the column token update after the read
module matrix_readout_ctrl
  import matrix_readout_pkg::*;
#(
  parameter int NCOL     = NCOL_DEF,
  parameter int DW       = DW_DEF,
  parameter int FRZ_WAIT = FRZ_WAIT_DEF,
  parameter int RD_LEN   = RD_LEN_DEF,
  parameter int TOK_WAIT = TOK_WAIT_DEF,
  parameter int CW       = (NCOL > 1) ? $clog2(NCOL) : 1
) (
  input  logic CLK,
  input  logic nRST,
  input  logic EN,
  output logic busy,
  matrix_readout_ctrl_if.master bus
);

  localparam int CNTW = cnt_width(FRZ_WAIT, RD_LEN, TOK_WAIT);
  localparam logic [CNTW-1:0] FRZ_LOAD = CNTW'(FRZ_WAIT - 1);
  localparam logic [CNTW-1:0] RD_LOAD  = CNTW'(RD_LEN - 1);
  localparam logic [CNTW-1:0] TOK_LOAD = CNTW'(TOK_WAIT - 1);

  state_t            state, state_nxt;
  logic [CNTW-1:0]   cnt, cnt_nxt;
  logic [CW-1:0]     col, col_nxt;
  logic [CW+DW-1:0]  word_q, word_nxt;
  logic [DW-1:0]     col_data;
  logic [NCOL-1:0]   read_q, read_nxt;
  logic              freeze_q, valid_q;
  logic              any_req;
  logic [CW-1:0]     low_idx;

  col_prio_enc #(.NCOL(NCOL), .CW(CW)) u_prio (
    .req (~bus.nTOK),
    .any (any_req),
    .idx (low_idx)
  );

  // Select the data bus of the column currently being read.
  always_comb begin
    col_data = '0;
    for (int c = 0; c < NCOL; c++) begin
      if (col == CW'(c)) col_data = bus.Data[c*DW +: DW];
    end
  end

  // Next-state logic; one down-counter times the FRZ, RD and TOKW waits.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    col_nxt   = col;
    word_nxt  = word_q;
    case (state)
      ST_IDLE: begin
        if (EN && any_req) begin
          if (FRZ_WAIT == 0) begin
            state_nxt = ST_SCAN;
          end else begin
            state_nxt = ST_FRZ;
            cnt_nxt   = FRZ_LOAD;
          end
        end
      end
      ST_FRZ: begin
        if (cnt == '0) state_nxt = ST_SCAN;
        else           cnt_nxt   = cnt - CNTW'(1);
      end
      ST_SCAN: begin
        if (!EN || !any_req) begin
          state_nxt = ST_IDLE;
        end else begin
          col_nxt   = low_idx;
          state_nxt = ST_RD;
          cnt_nxt   = RD_LOAD;
        end
      end
      ST_RD: begin
        if (cnt == '0) begin
          word_nxt  = {col, col_data};
          state_nxt = ST_OUT;
        end else begin
          cnt_nxt = cnt - CNTW'(1);
        end
      end
      ST_OUT: begin
        if (bus.out_ready) begin
          if (TOK_WAIT == 0) begin
            state_nxt = ST_SCAN;
          end else begin
            state_nxt = ST_TOKW;
            cnt_nxt   = TOK_LOAD;
          end
        end
      end
      ST_TOKW: begin
        if (cnt == '0) state_nxt = ST_SCAN;
        else           cnt_nxt   = cnt - CNTW'(1);
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Read strobe is decoded from the next state so it leaves a flop glitch-free.
  always_comb begin
    read_nxt = '0;
    if (state_nxt == ST_RD) read_nxt[col_nxt] = 1'b1;
  end

  // State, counter and registered outputs with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      col      <= '0;
      word_q   <= '0;
      read_q   <= '0;
      freeze_q <= 1'b0;
      valid_q  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      col      <= col_nxt;
      word_q   <= word_nxt;
      read_q   <= read_nxt;
      freeze_q <= (state_nxt != ST_IDLE);
      valid_q  <= (state_nxt == ST_OUT);
      busy     <= (state_nxt != ST_IDLE);
    end
  end

  assign bus.FREEZE    = {NCOL{freeze_q}};
  assign bus.Read      = read_q;
  assign bus.out_valid = valid_q;
  assign bus.out_data  = word_q;

endmodule

// File: tb/tb_matrix_readout_ctrl.sv
// Directed bench for matrix_readout_ctrl: vector table of single hits plus
// hand-written multi-cycle sequences.
module tb_matrix_readout_ctrl;

  localparam int NCOL = 56;
  localparam int DW   = 21;
  localparam int CW   = 6;
  localparam int OW   = CW + DW;
  localparam logic [NCOL-1:0] ALL1 = '1;

  logic CLK = 1'b0;
  logic nRST;
  logic EN;
  logic busy;

  matrix_readout_ctrl_if #(.NCOL(NCOL), .DW(DW), .CW(CW)) bus ();

  matrix_readout_ctrl #(
    .NCOL(NCOL), .DW(DW), .FRZ_WAIT(4), .RD_LEN(2), .TOK_WAIT(3), .CW(CW)
  ) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .EN   (EN),
    .busy (busy),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int multi_read = 0;
  int frz_bad  = 0;
  int hs_count = 0;
  bit mon_en   = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (mon_en) begin
      if ($countones(bus.Read) > 1) multi_read <= multi_read + 1;
      if (!((bus.FREEZE === ALL1 && busy === 1'b1) ||
            (bus.FREEZE === '0 && busy === 1'b0)))
        frz_bad <= frz_bad + 1;
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) hs_count <= hs_count + 1;
    end
  end

  typedef struct {
    int             col;
    logic [DW-1:0]  data;
    logic [OW-1:0]  exp_word;
  } vec_t;

  vec_t vecs[5];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_data(input int c, input logic [DW-1:0] v);
    bus.Data[c*DW +: DW] = v;
  endtask

  task automatic wait_valid(input int c, input int max, output int cycles,
                            output int rd_hits, output int idle_seen);
    logic [NCOL-1:0] oh;
    oh = '0;
    oh[c] = 1'b1;
    cycles = 0;
    rd_hits = 0;
    idle_seen = 0;
    while (bus.out_valid !== 1'b1 && cycles < max) begin
      tick();
      cycles++;
      if (bus.Read === oh) rd_hits++;
      if (busy !== 1'b1) idle_seen++;
    end
    check("wait_valid_reached", {63'd0, bus.out_valid === 1'b1}, 64'd1);
  endtask

  task automatic wait_idle(input int max);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < max) begin
      tick();
      n++;
    end
    check("wait_idle_reached", {63'd0, busy === 1'b0}, 64'd1);
  endtask

  initial begin
    int cy, rd, idl, hs0, bad;
    int t[3];
    logic [OW-1:0] word;

    vecs[0] = '{5,  21'h0ABCD,  27'h0A0ABCD};
    vecs[1] = '{0,  21'h1FFFFF, 27'h01FFFFF};
    vecs[2] = '{55, 21'h12345,  27'h6E12345};
    vecs[3] = '{31, 21'h000000, 27'h3E00000};
    vecs[4] = '{32, 21'h155555, 27'h4155555};

    nRST = 1'b0;
    EN = 1'b0;
    bus.nTOK = '1;
    bus.Data = '0;
    bus.out_ready = 1'b1;
    repeat (3) tick();
    check("rst_freeze", bus.FREEZE, 0);
    check("rst_read", bus.Read, 0);
    check("rst_valid", bus.out_valid, 0);
    check("rst_data", bus.out_data, 0);
    check("rst_busy", busy, 0);
    nRST = 1'b1;
    EN = 1'b1;
    mon_en = 1'b1;
    tick();

    // Single hits from the vector table, token released once the word shows.
    for (int i = 0; i < 5; i++) begin
      set_data(vecs[i].col, vecs[i].data);
      bus.nTOK[vecs[i].col] = 1'b0;
      tick();
      check("vec_freeze_rise", bus.FREEZE, ALL1);
      wait_valid(vecs[i].col, 20, cy, rd, idl);
      check("vec_latency", cy, 7);
      check("vec_read_cycles", rd, 2);
      check("vec_word", bus.out_data, vecs[i].exp_word);
      bus.nTOK[vecs[i].col] = 1'b1;
      tick();
      check("vec_valid_fall", bus.out_valid, 0);
      repeat (3) tick();
      check("vec_freeze_scan", bus.FREEZE, ALL1);
      tick();
      check("vec_freeze_drop", bus.FREEZE, 0);
      check("vec_idle", busy, 0);
    end

    // Simultaneous tokens: lower column first, frame never breaks.
    set_data(3, 21'h1);
    set_data(40, 21'h2);
    bus.nTOK[3] = 1'b0;
    bus.nTOK[40] = 1'b0;
    tick();
    wait_valid(3, 20, cy, rd, idl);
    check("sim_word0", bus.out_data, 27'h0600001);
    bus.nTOK[3] = 1'b1;
    tick();
    wait_valid(40, 20, cy, rd, idl);
    check("sim_word1", bus.out_data, 27'h5000002);
    check("sim_gap", cy, 6);
    check("sim_no_idle", idl, 0);
    bus.nTOK[40] = 1'b1;
    tick();
    wait_idle(20);

    // Backpressure: word held for 10 cycles, exactly one handshake.
    bus.out_ready = 1'b0;
    set_data(10, 21'h0F0F0);
    bus.nTOK[10] = 1'b0;
    tick();
    wait_valid(10, 20, cy, rd, idl);
    bus.nTOK[10] = 1'b1;
    word = bus.out_data;
    check("bp_word", word, 27'h140F0F0);
    hs0 = hs_count;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (bus.out_valid !== 1'b1 || bus.out_data !== word ||
          bus.Read !== '0 || bus.FREEZE !== ALL1) bad++;
    end
    check("bp_hold", bad, 0);
    bus.out_ready = 1'b1;
    tick();
    check("bp_valid_fall", bus.out_valid, 0);
    repeat (15) tick();
    check("bp_one_word", hs_count - hs0, 1);
    check("bp_idle", busy, 0);

    // Column 55 read three times while its token stays low.
    set_data(55, 21'h1);
    bus.nTOK[55] = 1'b0;
    tick();
    for (int w = 0; w < 3; w++) begin
      wait_valid(55, 30, cy, rd, idl);
      t[w] = cyc;
      check("multi_word", bus.out_data, 27'h6E00000 + 27'(w + 1));
      set_data(55, 21'(w + 2));
      if (w == 2) bus.nTOK[55] = 1'b1;
      tick();
    end
    check("multi_space01", t[1] - t[0], 7);
    check("multi_space12", t[2] - t[1], 7);
    wait_idle(20);

    // Reset during the second Read cycle discards the word.
    set_data(7, 21'h07777);
    bus.nTOK[7] = 1'b0;
    cy = 0;
    while (bus.Read[7] !== 1'b1 && cy < 20) begin
      tick();
      cy++;
    end
    check("rstrd_read_seen", bus.Read[7], 1);
    tick();
    hs0 = hs_count;
    nRST = 1'b0;
    tick();
    check("rstrd_freeze", bus.FREEZE, 0);
    check("rstrd_read", bus.Read, 0);
    check("rstrd_valid", bus.out_valid, 0);
    check("rstrd_busy", busy, 0);
    bus.nTOK[7] = 1'b1;
    nRST = 1'b1;
    repeat (15) tick();
    check("rstrd_no_word", hs_count - hs0, 0);

    // Enable gating: token waits while EN is low, frame starts right after.
    EN = 1'b0;
    set_data(0, 21'h0ABCD);
    bus.nTOK[0] = 1'b0;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (busy !== 1'b0 || bus.FREEZE !== '0) bad++;
    end
    check("en_gated", bad, 0);
    EN = 1'b1;
    tick();
    check("en_start_busy", busy, 1);
    check("en_start_freeze", bus.FREEZE, ALL1);
    wait_valid(0, 20, cy, rd, idl);
    check("en_word", bus.out_data, 27'h000ABCD);
    bus.nTOK[0] = 1'b1;
    tick();
    wait_idle(20);

    check("never_two_reads", multi_read, 0);
    check("freeze_busy_consistent", frz_bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
